// File: rtl/mem_arbiter.sv
// Serialises IF fetches and id_exe loads/stores onto one SRAM port; data requests win.
// Access takes ACCESS_CYCLES cycles, ack registered one cycle later; hold stalls the pipeline.
module mem_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ack,
    input  logic        flush,
    output logic        hold,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic        ram_doe,
    input  logic [15:0] ram_din,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam logic [15:0] LAST = 16'(ACCESS_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic        served_mem;
    logic        served_if;
    logic        if_flushed;
    logic        mem_pend;
    logic        if_pend;
    logic        in_access;
    logic        last;

    assign mem_pend  = (mem_read | mem_write) & ~served_mem;
    assign if_pend   = if_req & ~served_if & ~flush;
    assign in_access = (state != IDLE);
    assign last      = in_access && (cnt == LAST);
    assign hold      = mem_pend | if_pend | in_access;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes decode straight from the state register so reset forces them high at once.
    always_comb begin
        state_nxt = state;
        ram_en_n  = 1'b1;
        ram_oe_n  = 1'b1;
        ram_we_n  = 1'b1;
        ram_doe   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_pend && mem_write) begin
                    state_nxt = MEM_WR;
                end else if (mem_pend) begin
                    state_nxt = MEM_RD;
                end else if (if_pend) begin
                    state_nxt = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                ram_en_n = 1'b0;
                ram_oe_n = 1'b0;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            MEM_WR: begin
                ram_en_n = 1'b0;
                ram_doe  = 1'b1;
                // Release the write strobe one cycle early so address/data hold past it.
                ram_we_n = (cnt >= LAST);
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            ram_addr   <= '0;
            ram_dout   <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
            served_mem <= 1'b0;
            served_if  <= 1'b0;
            if_flushed <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            if (!hold || flush) begin
                served_mem <= 1'b0;
                served_if  <= 1'b0;
            end
            if (state == IDLE) begin
                cnt        <= '0;
                if_flushed <= 1'b0;
                if (state_nxt == MEM_WR) begin
                    ram_addr <= mem_addr;
                    ram_dout <= mem_wdata;
                end else if (state_nxt == MEM_RD) begin
                    ram_addr <= mem_addr;
                end else if (state_nxt == IF_RD) begin
                    ram_addr <= if_addr;
                end
            end else begin
                cnt <= cnt + 16'd1;
                if (flush) begin
                    if_flushed <= 1'b1;
                end
                // Completion sets its served flag after the flush clear above, so it wins.
                if (last) begin
                    if (state == IF_RD) begin
                        if (!(if_flushed || flush)) begin
                            if_rdata  <= ram_din;
                            served_if <= 1'b1;
                            if_ack    <= 1'b1;
                        end
                    end else begin
                        if (state == MEM_RD) begin
                            mem_rdata <= ram_din;
                        end
                        served_mem <= 1'b1;
                        mem_ack    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
